// File: rtl/morra_pkg.sv
// Shared encodings for the parameterised rock-paper-scissors game:
// move codes, round and game result codes, winner memory and FSM states.
package morra_pkg;

   typedef enum logic [1:0] {
      MV_NONE     = 2'b00,
      MV_ROCK     = 2'b01,
      MV_PAPER    = 2'b10,
      MV_SCISSORS = 2'b11
   } move_t;

   typedef enum logic [1:0] {
      RND_NONE = 2'b00,
      RND_P1   = 2'b01,
      RND_P2   = 2'b10,
      RND_TIE  = 2'b11
   } round_t;

   typedef enum logic [1:0] {
      GAME_RUN = 2'b00,
      GAME_P1  = 2'b01,
      GAME_P2  = 2'b10,
      GAME_TIE = 2'b11
   } game_t;

   typedef enum logic [1:0] {
      LW_NONE = 2'b00,
      LW_P1   = 2'b01,
      LW_P2   = 2'b10
   } winner_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_PLAY = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // True when move a defeats move b (both assumed to be real moves).
   function automatic logic beats(input move_t a, input move_t b);
      return (a == MV_ROCK     && b == MV_SCISSORS) ||
             (a == MV_SCISSORS && b == MV_PAPER)    ||
             (a == MV_PAPER    && b == MV_ROCK);
   endfunction

endpackage

// File: rtl/morra_judge.sv
// Combinational round judge: decides whether both moves are playable
// (non-empty, and not a repeat of the previous winner's winning move)
// and, if so, who wins the round.
module morra_judge
   import morra_pkg::*;
#(
   parameter int NO_REPEAT = 1
) (
   input  move_t   p1,
   input  move_t   p2,
   input  winner_t last_win,
   input  move_t   last_move,
   output logic    valid,
   output round_t  result
);

   logic p1_ok;
   logic p2_ok;

   // Validity of each move, then the standard rules on a valid pair.
   // NOTE: every signal written here gets a default first so no path can infer a latch.
   always_comb begin
      p1_ok  = 1'b0;
      p2_ok  = 1'b0;
      valid  = 1'b0;
      result = RND_NONE;

      p1_ok = (p1 != MV_NONE) &&
              !((NO_REPEAT != 0) && (last_win == LW_P1) && (p1 == last_move));
      p2_ok = (p2 != MV_NONE) &&
              !((NO_REPEAT != 0) && (last_win == LW_P2) && (p2 == last_move));
      valid = p1_ok && p2_ok;

      if (valid) begin
         if (p1 == p2)
            result = RND_TIE;
         else if (beats(p1, p2))
            result = RND_P1;
         else
            result = RND_P2;
      end
   end

endmodule

// File: rtl/morra_cinese_param.sv
// Parameterised rock-paper-scissors match controller. A game lasts at
// least MIN_ROUNDS valid rounds and at most a limit chosen at START; it
// ends early once one player leads by WIN_MARGIN. All outputs registered.
module morra_cinese_param
   import morra_pkg::*;
#(
   parameter  int MIN_ROUNDS = 4,
   parameter  int MAX_EXTRA  = 15,
   parameter  int WIN_MARGIN = 2,
   parameter  int NO_REPEAT  = 1,
   localparam int CNT_W      = $clog2(MIN_ROUNDS + MAX_EXTRA + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       p1,
   input  logic [1:0]       p2,
   input  logic             start,
   output logic [1:0]       round,
   output logic [1:0]       game,
   output logic [CNT_W-1:0] played
);

   localparam int                     DW        = CNT_W + 1;
   localparam logic [3:0]             EXTRA_CAP = 4'(MAX_EXTRA);
   localparam logic [CNT_W-1:0]       MIN_R     = CNT_W'(MIN_ROUNDS);
   localparam logic [CNT_W-1:0]       CNT_ONE   = CNT_W'(1);
   localparam logic [DW-1:0]          MARGIN    = DW'(WIN_MARGIN);
   localparam logic signed [DW-1:0]   D_ONE     = DW'(1);

   state_t                  state_q,  state_d;
   round_t                  round_q,  round_d;
   game_t                   game_q,   game_d;
   logic [CNT_W-1:0]        played_q, played_d;
   logic [CNT_W-1:0]        limit_q,  limit_d;
   logic signed [DW-1:0]    diff_q,   diff_d;
   winner_t                 lw_q,     lw_d;
   move_t                   lm_q,     lm_d;

   move_t            m1;
   move_t            m2;
   logic             valid;
   round_t           result;
   logic [3:0]       req;
   logic [3:0]       extra;
   logic [DW-1:0]    mag;

   assign m1    = move_t'(p1);
   assign m2    = move_t'(p2);
   assign req   = {p1, p2};
   assign extra = (req > EXTRA_CAP) ? EXTRA_CAP : req;

   morra_judge #(
      .NO_REPEAT (NO_REPEAT)
   ) u_judge (
      .p1        (m1),
      .p2        (m2),
      .last_win  (lw_q),
      .last_move (lm_q),
      .valid     (valid),
      .result    (result)
   );

   // Next-state and next-output logic for the IDLE/PLAY/DONE game FSM.
   always_comb begin
      state_d  = state_q;
      round_d  = RND_NONE;
      game_d   = game_q;
      played_d = played_q;
      limit_d  = limit_q;
      diff_d   = diff_q;
      lw_d     = lw_q;
      lm_d     = lm_q;
      mag      = '0;

      if (start) begin
         state_d  = ST_PLAY;
         limit_d  = MIN_R + CNT_W'(extra);
         played_d = '0;
         diff_d   = '0;
         lw_d     = LW_NONE;
         lm_d     = MV_NONE;
         game_d   = GAME_RUN;
      end else begin
         case (state_q)
            ST_IDLE: begin
               game_d   = GAME_RUN;
               played_d = '0;
            end
            ST_PLAY: begin
               if (valid) begin
                  round_d  = result;
                  played_d = played_q + CNT_ONE;
                  case (result)
                     RND_P1: begin
                        diff_d = diff_q + D_ONE;
                        lw_d   = LW_P1;
                        lm_d   = m1;
                     end
                     RND_P2: begin
                        diff_d = diff_q - D_ONE;
                        lw_d   = LW_P2;
                        lm_d   = m2;
                     end
                     default: begin
                        lw_d = LW_NONE;
                        lm_d = MV_NONE;
                     end
                  endcase

                  mag = diff_d[DW-1] ? DW'(-diff_d) : DW'(diff_d);

                  // The limit check also keeps PLAYED from ever passing it.
                  if (((played_d >= MIN_R) && (mag >= MARGIN)) || (played_d == limit_q)) begin
                     state_d = ST_DONE;
                     if (diff_d == '0)
                        game_d = GAME_TIE;
                     else if (diff_d[DW-1])
                        game_d = GAME_P2;
                     else
                        game_d = GAME_P1;
                  end
               end
            end
            ST_DONE: begin
               // Result and count hold; moves are ignored until the next START.
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and output registers; reset aborts any game immediately.
   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         round_q  <= RND_NONE;
         game_q   <= GAME_RUN;
         played_q <= '0;
         limit_q  <= MIN_R;
         diff_q   <= '0;
         lw_q     <= LW_NONE;
         lm_q     <= MV_NONE;
      end else begin
         state_q  <= state_d;
         round_q  <= round_d;
         game_q   <= game_d;
         played_q <= played_d;
         limit_q  <= limit_d;
         diff_q   <= diff_d;
         lw_q     <= lw_d;
         lm_q     <= lm_d;
      end
   end

   assign round  = round_q;
   assign game   = game_q;
   assign played = played_q;

endmodule

// File: tb/tb_morra_cinese_param.sv
// Bench for morra_cinese_param: a default instance and one with
// MAX_EXTRA=3, driven from shared inputs. Expected outputs are queued
// with each stimulus cycle and compared one edge later.
module tb_morra_cinese_param;

   logic       clk;
   logic       rst;
   logic [1:0] p1;
   logic [1:0] p2;
   logic       start;

   logic [1:0] round_a, game_a;
   logic [4:0] played_a;
   logic [1:0] round_b, game_b;
   logic [2:0] played_b;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string      name;
      bit         sel;
      logic [1:0] r;
      logic [1:0] g;
      int         pl;
   } exp_t;

   exp_t sb[$];

   morra_cinese_param dut_a (
      .clk    (clk),
      .rst    (rst),
      .p1     (p1),
      .p2     (p2),
      .start  (start),
      .round  (round_a),
      .game   (game_a),
      .played (played_a)
   );

   morra_cinese_param #(
      .MAX_EXTRA (3)
   ) dut_b (
      .clk    (clk),
      .rst    (rst),
      .p1     (p1),
      .p2     (p2),
      .start  (start),
      .round  (round_b),
      .game   (game_b),
      .played (played_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one cycle of stimulus, queue its expectation, then score after the edge.
   task automatic step(input logic s, input logic [1:0] a, input logic [1:0] b,
                       input string name, input bit sel,
                       input logic [1:0] er, input logic [1:0] eg, input int ep);
      exp_t e;
      start = s;
      p1    = a;
      p2    = b;
      e     = '{name, sel, er, eg, ep};
      sb.push_back(e);
      @(posedge clk);
      #1;
      score();
   endtask

   task automatic score();
      exp_t       e;
      logic [1:0] r;
      logic [1:0] g;
      int         pl;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty: got 0 entries, required 1");
         return;
      end
      e = sb.pop_front();
      if (e.sel) begin
         r = round_b; g = game_b; pl = int'(played_b);
      end else begin
         r = round_a; g = game_a; pl = int'(played_a);
      end
      if (r !== e.r) begin
         errors++;
         $display("FAIL %s round: got %b required %b", e.name, r, e.r);
      end
      checks++;
      if (g !== e.g) begin
         errors++;
         $display("FAIL %s game: got %b required %b", e.name, g, e.g);
      end
      checks++;
      if (pl !== e.pl) begin
         errors++;
         $display("FAIL %s played: got %0d required %0d", e.name, pl, e.pl);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; p1 = 2'b00; p2 = 2'b00;
      #3;
      checks++;
      if ({round_a, game_a, played_a} !== 9'd0) begin
         errors++;
         $display("FAIL reset_a: got %b required 0", {round_a, game_a, played_a});
      end
      checks++;
      if ({round_b, game_b, played_b} !== 7'd0) begin
         errors++;
         $display("FAIL reset_b: got %b required 0", {round_b, game_b, played_b});
      end
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_idle();
      step(1'b0, 2'b01, 2'b10, "idle1", 1'b0, 2'b00, 2'b00, 0);
      step(1'b0, 2'b11, 2'b01, "idle2", 1'b0, 2'b00, 2'b00, 0);
   endtask

   task automatic test_start_and_repeat();
      step(1'b1, 2'b01, 2'b10, "start10",   1'b0, 2'b00, 2'b00, 0);
      step(1'b0, 2'b00, 2'b01, "p1_none",   1'b0, 2'b00, 2'b00, 0);
      step(1'b0, 2'b01, 2'b11, "rock_win",  1'b0, 2'b01, 2'b00, 1);
      step(1'b0, 2'b01, 2'b10, "p1_repeat", 1'b0, 2'b00, 2'b00, 1);
   endtask

   task automatic test_margin_win();
      step(1'b1, 2'b01, 2'b10, "mw_start", 1'b0, 2'b00, 2'b00, 0);
      step(1'b0, 2'b01, 2'b11, "mw_r1",    1'b0, 2'b01, 2'b00, 1);
      step(1'b0, 2'b10, 2'b01, "mw_r2",    1'b0, 2'b01, 2'b00, 2);
      step(1'b0, 2'b11, 2'b10, "mw_r3",    1'b0, 2'b01, 2'b00, 3);
      step(1'b0, 2'b01, 2'b11, "mw_r4",    1'b0, 2'b01, 2'b01, 4);
      step(1'b0, 2'b10, 2'b01, "mw_done1", 1'b0, 2'b00, 2'b01, 4);
      step(1'b0, 2'b00, 2'b11, "mw_done2", 1'b0, 2'b00, 2'b01, 4);
   endtask

   task automatic test_ties();
      step(1'b1, 2'b00, 2'b00, "tie_start", 1'b0, 2'b00, 2'b00, 0);
      step(1'b0, 2'b01, 2'b01, "tie_r1",    1'b0, 2'b11, 2'b00, 1);
      step(1'b0, 2'b10, 2'b10, "tie_r2",    1'b0, 2'b11, 2'b00, 2);
      step(1'b0, 2'b11, 2'b11, "tie_r3",    1'b0, 2'b11, 2'b00, 3);
      step(1'b0, 2'b01, 2'b01, "tie_r4",    1'b0, 2'b11, 2'b11, 4);
      step(1'b0, 2'b01, 2'b11, "tie_done",  1'b0, 2'b00, 2'b11, 4);
   endtask

   task automatic test_p2_limit();
      step(1'b1, 2'b00, 2'b00, "p2_start",  1'b0, 2'b00, 2'b00, 0);
      step(1'b0, 2'b01, 2'b10, "p2_r1",     1'b0, 2'b10, 2'b00, 1);
      step(1'b0, 2'b11, 2'b10, "p2_repeat", 1'b0, 2'b00, 2'b00, 1);
      step(1'b0, 2'b01, 2'b01, "p2_r2",     1'b0, 2'b11, 2'b00, 2);
      step(1'b0, 2'b11, 2'b10, "p2_r3",     1'b0, 2'b01, 2'b00, 3);
      step(1'b0, 2'b01, 2'b10, "p2_r4",     1'b0, 2'b10, 2'b10, 4);
   endtask

   task automatic test_max_extra();
      logic [1:0] mv;
      step(1'b1, 2'b11, 2'b11, "mx_start",   1'b1, 2'b00, 2'b00, 0);
      step(1'b0, 2'b10, 2'b10, "mx_t1",      1'b1, 2'b11, 2'b00, 1);
      step(1'b0, 2'b11, 2'b11, "mx_t2",      1'b1, 2'b11, 2'b00, 2);
      step(1'b1, 2'b11, 2'b11, "mx_restart", 1'b1, 2'b00, 2'b00, 0);
      for (int i = 1; i <= 7; i++) begin
         mv = 2'((i % 3) + 1);
         step(1'b0, mv, mv, $sformatf("mx_tie%0d", i), 1'b1,
              2'b11, (i == 7) ? 2'b11 : 2'b00, i);
      end
   endtask

   task automatic test_reset_mid();
      step(1'b1, 2'b00, 2'b00, "rm_start", 1'b0, 2'b00, 2'b00, 0);
      step(1'b0, 2'b10, 2'b10, "rm_tie",   1'b0, 2'b11, 2'b00, 1);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({round_a, game_a, played_a} !== 9'd0) begin
         errors++;
         $display("FAIL reset_mid: got %b required 0", {round_a, game_a, played_a});
      end
      #2 rst = 1'b0;
      step(1'b0, 2'b01, 2'b11, "rm_idle1", 1'b0, 2'b00, 2'b00, 0);
      step(1'b0, 2'b10, 2'b01, "rm_idle2", 1'b0, 2'b00, 2'b00, 0);
   endtask

   initial begin
      test_reset();
      test_idle();
      test_start_and_repeat();
      test_margin_win();
      test_ties();
      test_p2_limit();
      test_max_extra();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/morra_cinese_param.md
MORRA_CINESE_PARAM -- requirements
Module: morra_cinese_param

Interface
REQ-001 Parameter MIN_ROUNDS, default 4: valid rounds always played before a margin win can end the game.
REQ-002 Parameter MAX_EXTRA, default 15: cap on extra rounds requested at START; range 0..15.
REQ-003 Parameter WIN_MARGIN, default 2: score lead that ends the game early; range 1..MIN_ROUNDS.
REQ-004 Parameter NO_REPEAT, default 1: when 1, last round's winner may not replay its winning move.
REQ-005 Local CNT_W = clog2(MIN_ROUNDS+MAX_EXTRA+1).
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 P1  in  2  player-1 move: 00 none, 01 rock, 10 paper, 11 scissors.
REQ-009 P2  in  2  player-2 move, same encoding.
REQ-010 START  in  1  starts or restarts a game; {P1,P2} carries the extra-round request in that cycle.
REQ-011 ROUND  out  2  registered round result: 00 invalid/none, 01 P1 wins, 10 P2 wins, 11 tie.
REQ-012 GAME  out  2  registered game result: 00 in progress/idle, 01 P1 wins, 10 P2 wins, 11 tie.
REQ-013 PLAYED  out  CNT_W  registered count of valid rounds in the current game.

Function
REQ-014 States IDLE, PLAY, DONE; every output is registered and reflects inputs sampled at the previous rising edge, one cycle of latency.
REQ-015 In any state, START=1 sets limit = MIN_ROUNDS + min({P1,P2}, MAX_EXTRA), clears PLAYED, score difference and last-winner memory, drives ROUND=00 and GAME=00, and enters PLAY.
REQ-016 In IDLE with START=0, the block stays in IDLE and all outputs stay 0.
REQ-017 In PLAY a move is invalid if it is 00, or if NO_REPEAT=1 and that player won the last valid round and repeats its winning move.
REQ-018 Any invalid move from either player: ROUND=00; PLAYED, score and last-winner memory unchanged.
REQ-019 Both moves valid: standard rules apply (rock>scissors, scissors>paper, paper>rock, equal=tie); ROUND takes the result and PLAYED increments.
REQ-020 A win adds +1 (P1) or -1 (P2) to a signed difference of width CNT_W+1 and records winner and move; a tie leaves the difference unchanged and clears last-winner memory.
REQ-021 After a valid round the game ends when (PLAYED_new >= MIN_ROUNDS and |diff| >= WIN_MARGIN) or PLAYED_new == limit.
REQ-022 At game end GAME = 01 if diff>0, 10 if diff<0, 11 if diff==0, in the same cycle as the final ROUND; the state becomes DONE.
REQ-023 In DONE with START=0: GAME holds, ROUND=00, PLAYED holds, and P1/P2 are ignored.
REQ-024 PLAYED never exceeds limit; counters never wrap.

Reset
REQ-025 rst=1 immediately forces IDLE, ROUND=00, GAME=00, PLAYED=0, diff=0, limit=MIN_ROUNDS and last winner = none, with no clock edge required.
REQ-026 Reset asserted mid-game aborts the game; the game is not resumed after release.

Structure
REQ-027 Package morra_pkg holds move encodings, round/game result encodings and the state enum.
REQ-028 Combinational sub-module morra_judge takes the two moves plus last-winner info and returns validity and round result; the top module holds the FSM and counters.

Verification (defaults)
REQ-029 Reset, then START=1 with P1=01, P2=10 -> limit=10, ROUND=00, GAME=00, PLAYED=0.
REQ-030 In PLAY, P1=00, P2=01 -> ROUND=00, PLAYED unchanged; next P1=01, P2=11 -> ROUND=01, PLAYED=1; next P1=01, P2=10 -> ROUND=00 (repeat rule), PLAYED=1.
REQ-031 P1 wins four valid rounds in a row with varied moves -> GAME stays 00 for rounds 1-3 despite diff>=2; round 4 -> GAME=01, DONE; further moves leave GAME=01, ROUND=00.
REQ-032 START with P1=00, P2=00 (limit 4), then four ties -> fourth cycle ROUND=11, GAME=11, PLAYED=4.
REQ-033 START with {P1,P2}=1111 while MAX_EXTRA=3 -> limit=7; START reasserted mid-game -> PLAYED=0, GAME=00.
REQ-034 rst pulsed between clock edges mid-game -> outputs 0 before the next edge; IDLE after release.
